// File: rtl/iram_loader.sv
// iram_loader: streams a byte image into the instruction RAM over an
// AHB-lite-style port, then optionally reads it back to check the sum.
module iram_loader #(
    parameter logic [16:0] BASE_ADDR = 17'h0,
    parameter int          MAX_LEN   = 256,
    parameter int          VERIFY    = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [8:0]  len,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [16:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [16:0] HWDATA,
    output logic        HWRITE,
    input  logic [16:0] HRDATA,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [9:0] MAX_LEN_W = 10'(MAX_LEN);

    logic [2:0]  state_q, state_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  idx_q, idx_d;
    logic [16:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [16:0] hwdata_q, hwdata_d;
    logic        hwrite_q, hwrite_d;
    logic        rd_q, rd_d;
    logic        rvalid_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] rsum_q, rsum_d;
    logic        hierr_q, hierr_d;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        haddr_d  = haddr_q;
        htrans_d = 2'b00;
        hwdata_d = hwdata_q;
        hwrite_d = 1'b0;
        rd_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        csum_d   = csum_q;
        rsum_d   = rsum_q;
        hierr_d  = hierr_q;
        // rvalid_q marks the cycle in which the iram returns read data
        if (rvalid_q) begin
            rsum_d = rsum_q + {8'h00, HRDATA[7:0]};
            if (HRDATA[16:8] != 9'd0) hierr_d = 1'b1;
        end
        if (done_q) busy_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && !busy_q) begin
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    csum_d  = 16'h0;
                    rsum_d  = 16'h0;
                    hierr_d = 1'b0;
                    idx_d   = 9'd0;
                    len_d   = len;
                    if (len == 9'd0) begin
                        state_d = S_FIN;
                    end else if ({1'b0, len} > MAX_LEN_W) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid) begin
                    hwrite_d = 1'b1;
                    htrans_d = hwrite_q ? 2'b11 : 2'b10;
                    haddr_d  = BASE_ADDR + 17'(idx_q);
                    hwdata_d = {9'b0, s_data};
                    csum_d   = csum_q + {8'h00, s_data};
                    if (idx_q == len_q - 9'd1) begin
                        idx_d   = 9'd0;
                        state_d = (VERIFY != 0) ? S_VERIFY : S_FIN;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_VERIFY: begin
                rd_d     = 1'b1;
                htrans_d = (idx_q == 9'd0) ? 2'b10 : 2'b11;
                haddr_d  = BASE_ADDR + 17'(idx_q);
                if (idx_q == len_q - 9'd1) begin
                    idx_d   = 9'd0;
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + 9'd1;
                end
            end
            S_DRAIN: begin
                if (rvalid_q && !rd_q) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rsum_q != csum_q || hierr_q) error_d = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q  <= S_IDLE;
            len_q    <= 9'd0;
            idx_q    <= 9'd0;
            haddr_q  <= 17'd0;
            htrans_q <= 2'b00;
            hwdata_q <= 17'd0;
            hwrite_q <= 1'b0;
            rd_q     <= 1'b0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            csum_q   <= 16'h0;
            rsum_q   <= 16'h0;
            hierr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            hwrite_q <= hwrite_d;
            rd_q     <= rd_d;
            rvalid_q <= rd_q;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            csum_q   <= csum_d;
            rsum_q   <= rsum_d;
            hierr_q  <= hierr_d;
        end
    end

    assign s_ready  = (state_q == S_LOAD);
    assign HADDR    = haddr_q;
    assign HTRANS   = htrans_q;
    assign HWDATA   = hwdata_q;
    assign HWRITE   = hwrite_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign checksum = csum_q;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader with a small behavioural iram
// and a per-cycle bus trace taken on the falling clock edge.
module tb_iram_loader;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic [8:0]  len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [16:0] HADDR;
    logic [1:0]  HTRANS;
    logic [16:0] HWDATA;
    logic        HWRITE;
    logic [16:0] HRDATA;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    iram_loader dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .len(len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HRDATA(HRDATA), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    always #5 HCLK = ~HCLK;

    // iram model: write when HWRITE, else registered read
    logic [16:0] mem [0:511];
    logic        clr_mem = 1'b1;
    logic        corrupt = 1'b0;
    always @(posedge HCLK) begin
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) mem[i] <= 17'd0;
        end else if (HWRITE) begin
            mem[HADDR[8:0]] <= HWDATA;
        end
        if (!HWRITE)
            HRDATA <= (corrupt && HADDR == 17'd2) ? 17'd0 : mem[HADDR[8:0]];
    end

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        srdy;
        logic        hw;
        logic [1:0]  ht;
        logic [16:0] ha;
        logic [16:0] hd;
    } tr_t;

    tr_t tr[$];
    logic log_en = 1'b0;
    int done_cnt;
    int done_idx;
    always @(negedge HCLK) begin
        if (log_en) begin
            tr.push_back('{busy, done, s_ready, HWRITE, HTRANS, HADDR, HWDATA});
            if (done) begin
                done_cnt++;
                done_idx = tr.size() - 1;
            end
        end
    end

    int nchk = 0;
    int nerr = 0;
    logic [7:0] dat [0:299];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic tr_t at(input int i);
        if (i < 0 || i >= tr.size()) return '0;
        return tr[i];
    endfunction

    function automatic int nwrites();
        int c = 0;
        foreach (tr[i]) if (tr[i].hw) c++;
        return c;
    endfunction

    task automatic run(input int n, input int gap_at, input int gap_len,
                       input int dup_at);
        int t;
        clr_mem = 1'b1;
        @(posedge HCLK);
        #1 clr_mem = 1'b0;
        tr.delete();
        done_cnt = 0;
        done_idx = -1;
        start = 1'b1;
        len = 9'(n);
        @(posedge HCLK);
        #1 start = 1'b0;
        log_en = 1'b1;
        if (n >= 1 && n <= 256) begin
            for (int i = 0; i < n; i++) begin
                if (i == gap_at) begin
                    s_valid = 1'b0;
                    repeat (gap_len) @(posedge HCLK);
                    #1;
                end
                s_valid = 1'b1;
                s_data = dat[i];
                if (i == dup_at) begin
                    start = 1'b1;
                    len = 9'd1;
                end
                @(posedge HCLK);
                #1 start = 1'b0;
            end
        end
        s_valid = 1'b0;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(posedge HCLK);
            t++;
        end
        repeat (2) @(posedge HCLK);
        #1 log_en = 1'b0;
        check("done_seen", 32'(done_cnt), 32'd1);
        check("busy_at_done", 32'(at(done_idx).busy), 32'd1);
        check("busy_after_done", 32'(at(done_idx + 1).busy), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_bus"}, {13'd0, HWRITE, HTRANS, HADDR}, 32'd0);
        check({tag, "_wdata"}, 32'(HWDATA), 32'd0);
        check({tag, "_flags"}, {28'd0, busy, done, error, s_ready}, 32'd0);
        check({tag, "_csum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        HRESET = 1'b0;
        start = 1'b0;
        len = 9'd0;
        s_data = 8'd0;
        s_valid = 1'b0;
        dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'hFF; dat[3] = 8'h01;
        #12 chk_idle("reset");
        @(negedge HCLK) HRESET = 1'b1;

        // len=4 continuous
        run(4, -1, 0, -1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr%0d_hw", i), 32'(at(1 + i).hw), 32'd1);
            check($sformatf("wr%0d_ha", i), 32'(at(1 + i).ha), 32'(i));
            check($sformatf("wr%0d_hd", i), 32'(at(1 + i).hd), 32'(dat[i]));
            check($sformatf("wr%0d_ht", i), 32'(at(1 + i).ht),
                  (i == 0) ? 32'd2 : 32'd3);
            check($sformatf("rd%0d_bus", i),
                  {13'd0, at(5 + i).hw, at(5 + i).ht, at(5 + i).ha},
                  {13'd0, 1'b0, (i == 0) ? 2'd2 : 2'd3, 17'(i)});
        end
        check("c4_first_idle", 32'(at(0).ht), 32'd0);
        check("c4_drain_idle", 32'(at(9).ht), 32'd0);
        check("c4_srdy_last", 32'(at(4).srdy), 32'd0);
        check("c4_nwr", 32'(nwrites()), 32'd4);
        check("c4_csum", 32'(checksum), 32'h1E1);
        check("c4_err", 32'(error), 32'd0);
        check("c4_latency", 32'(done_idx), 32'd12);

        // two-cycle stall before byte 2
        run(4, 2, 2, -1);
        for (int i = 3; i < 5; i++)
            check($sformatf("gap%0d", i),
                  {13'd0, at(i).hw, at(i).ht, at(i).ha}, 32'd1);
        check("gap_resume", {13'd0, at(5).hw, at(5).ht, at(5).ha},
              {13'd0, 1'b1, 2'd2, 17'd2});
        check("gap_next", {13'd0, at(6).hw, at(6).ht, at(6).ha},
              {13'd0, 1'b1, 2'd3, 17'd3});
        for (int i = 0; i < 4; i++)
            check($sformatf("gap_mem%0d", i), 32'(mem[i]), 32'(dat[i]));
        check("gap_csum", 32'(checksum), 32'h1E1);
        check("gap_err", 32'(error), 32'd0);
        check("gap_latency", 32'(done_idx), 32'd14);

        // corrupted readback of address 2
        corrupt = 1'b1;
        run(4, -1, 0, -1);
        corrupt = 1'b0;
        check("bad_err", 32'(error), 32'd1);
        check("bad_csum", 32'(checksum), 32'h1E1);

        // len=0 clears the previous error
        run(0, -1, 0, -1);
        check("z_nwr", 32'(nwrites()), 32'd0);
        check("z_err", 32'(error), 32'd0);
        check("z_latency", 32'(done_idx), 32'd1);

        // over-length request
        run(300, -1, 0, -1);
        check("big_nwr", 32'(nwrites()), 32'd0);
        check("big_err", 32'(error), 32'd1);
        check("big_csum", 32'(checksum), 32'd0);

        // start pulse during LOAD is ignored
        dat[0] = 8'h10; dat[1] = 8'h20; dat[2] = 8'h30;
        run(3, -1, 0, 1);
        check("dup_nwr", 32'(nwrites()), 32'd3);
        check("dup_csum", 32'(checksum), 32'h60);
        check("dup_err", 32'(error), 32'd0);
        check("dup_latency", 32'(done_idx), 32'd10);

        // full-size image, data = index
        for (int i = 0; i < 256; i++) dat[i] = 8'(i);
        run(256, -1, 0, -1);
        check("max_nwr", 32'(nwrites()), 32'd256);
        check("max_last", {13'd0, at(256).hw, at(256).ht, at(256).ha},
              {13'd0, 1'b1, 2'd3, 17'd255});
        check("max_csum", 32'(checksum), 32'h7F80);
        check("max_err", 32'(error), 32'd0);
        check("max_latency", 32'(done_idx), 32'd516);

        // asynchronous reset in the middle of LOAD
        @(posedge HCLK);
        #1 start = 1'b1;
        len = 9'd4;
        @(posedge HCLK);
        #1 start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hA5;
        @(posedge HCLK);
        #1 s_data = 8'h3C;
        @(posedge HCLK);
        #1 s_valid = 1'b0;
        check("pre_rst_hw", 32'(HWRITE), 32'd1);
        #3 HRESET = 1'b0;
        #1 chk_idle("midrst");
        @(posedge HCLK);
        #1 HRESET = 1'b1;
        dat[0] = 8'h5A;
        run(1, -1, 0, -1);
        check("post_csum", 32'(checksum), 32'h5A);
        check("post_err", 32'(error), 32'd0);
        check("post_nwr", 32'(nwrites()), 32'd1);
        check("post_latency", 32'(done_idx), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/iram_loader.md
Name: iram_loader

Overview:
- AHB-lite-style bus initiator that fills the on-chip instruction RAM from a byte stream (boot/debug loader), then optionally reads the image back to verify it.
- Sits between the byte-source front end (UART/JTAG bridge) and the iram slave port.
- The iram slave decodes any in-range address every cycle. It writes when HWRITE=1, otherwise registers HRDATA one cycle later, and ignores HTRANS. This block therefore keeps HWRITE=0 whenever no write beat is intended.

Parameters:
- BASE_ADDR, 17'h0, first iram address written.
- MAX_LEN, 256, maximum image length in bytes; BASE_ADDR+MAX_LEN ≤ 2^17 is required (no address wrap).
- VERIFY, 1, 1 = run readback checksum pass after load; 0 = skip.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  asynchronous active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- len  in  9  image length in bytes, captured on start.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts a byte (combinational: state==LOAD).
- HADDR  out  17  bus address.
- HTRANS  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- HWDATA  out  17  write data, {9'b0, byte}.
- HWRITE  out  1  write strobe.
- HRDATA  in  17  read data from iram, valid the cycle after the address is presented.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky until next accepted start.
- checksum  out  16  sum mod 2^16 of bytes loaded.

Behaviour:
- Reset (asynchronous, HRESET=0): all outputs go to 0, i.e. HADDR, HTRANS=00, HWDATA, HWRITE, busy, done, error, checksum. State returns to IDLE and internal counters clear. Reset mid-operation aborts immediately; memory contents are then undefined for the bench.
- All bus outputs are registered.
- States: IDLE, LOAD, VERIFY, DRAIN, CHECK, FIN.
- IDLE:
  - start=1 with 1 ≤ len ≤ MAX_LEN: capture len, clear error/checksum/index, set busy, go to LOAD.
  - start=1 with len=0: go to FIN with no bus beats.
  - start=1 with len>MAX_LEN: set error, go to FIN with no bus beats.
  - start while busy is ignored.
- LOAD: each edge where s_valid && s_ready registers one write beat into the next cycle:
  - HADDR=BASE_ADDR+idx, HWDATA={9'b0,s_data}, HWRITE=1.
  - HTRANS=10 if the previous cycle carried no beat, else 11.
  - checksum += s_data; idx++.
  - On an edge without a handshake: HWRITE=0, HTRANS=00, HADDR holds.
  - Acceptance of byte idx==len-1 moves the state to VERIFY (if VERIFY=1) or FIN. s_ready therefore drops the cycle the final write beat is on the bus. Throughput is 1 byte/cycle.
- VERIFY: presents read beats HADDR=BASE_ADDR+k for k=0..len-1, one per cycle.
  - HWRITE=0; HTRANS=10 for k=0, else 11.
  - The first read address is driven the cycle after the last write beat, so there is no write/read overlap.
  - In the cycle after address k is presented, HRDATA[7:0] is added to a 16-bit readback sum.
  - After k=len-1 is presented, go to DRAIN. DRAIN drives HTRANS=00 and accumulates the final byte.
- CHECK: error is set if readback sum ≠ checksum or any sampled HRDATA[16:8] ≠ 0. Then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 on the following cycle, return to IDLE. error and checksum hold until the next accepted start.
- Bus idle outside LOAD/VERIFY beats: HWRITE=0, HTRANS=00.
- Latency for len=N, VERIFY=1, continuous s_valid: done asserts N+N+4 cycles after start acceptance (±1 is a spec violation).

Test Plan:
- Reset: assert HRESET mid-LOAD after 2 bytes -> all outputs 0 asynchronously, s_ready=0; after release, start len=1 works normally.
- len=4, bytes A5,3C,FF,01, s_valid held high -> write beats HADDR 0..3 on consecutive cycles, HTRANS 10,11,11,11, HWDATA 0x0A5..0x001. Then reads 0..3. checksum=0x01E1, error=0, one done pulse.
- Same 4 bytes with s_valid low for 2 cycles between bytes 2 and 3 -> gap cycles show HWRITE=0, HTRANS=00, HADDR held at 1; next beat HADDR=2 with HTRANS=10; iram contents identical.
- len=256, data=index -> last write HADDR=BASE_ADDR+255, checksum=0x7F80, error=0.
- VERIFY: bench corrupts HRDATA for address 2 (returns 0x000) -> error=1, done pulse, checksum=0x01E1 unchanged.
- Corner starts:
  - len=0 -> done pulse, no HWRITE beats, error=0.
  - len=300 -> error=1, done, no beats.
  - start pulsed during LOAD -> ignored, len unchanged.
